// File: rtl/combo_lock_fsm_if.sv
// Dial/button/door inputs and lock/display/counter controls for combo_lock_fsm.
interface combo_lock_fsm_if #(
    parameter int unsigned SEL_W = 2
);
    logic             dirch;
    logic [3:0]       bcd0;
    logic [3:0]       bcd1;
    logic             lock;
    logic             open;
    logic             doorCls;
    logic             actuateLock;
    logic             openCls;
    logic             countEn;
    logic             clrCount;
    logic             blank;
    logic [SEL_W-1:0] sel;

    modport master (
        output dirch, bcd0, bcd1, lock, open, doorCls,
        input  actuateLock, openCls, countEn, clrCount, blank, sel
    );

    modport slave (
        input  dirch, bcd0, bcd1, lock, open, doorCls,
        output actuateLock, openCls, countEn, clrCount, blank, sel
    );
endinterface

// File: rtl/combo_lock_fsm.sv
// N-entry combination-lock controller. Define COMBO_LOCK_LOCKOUT_EN to add the
// failed-attempt counter and timed LOCKOUT state.
module combo_lock_fsm #(
    parameter int unsigned           DIGITS     = 3,
    parameter int unsigned           SEL_W      = 2,
    parameter logic [8*DIGITS-1:0]   CODE       = 24'h074215,
    parameter int unsigned           MAX_TRIES  = 3,
    parameter int unsigned           LOCKOUT_MS = 5000
) (
    input  logic            clk,
    input  logic            reset,
    combo_lock_fsm_if.slave bus
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(DIGITS - 1);

    if (DIGITS < 2 || DIGITS > 8 || (1 << SEL_W) < DIGITS ||
        MAX_TRIES == 0 || LOCKOUT_MS == 0) begin : g_param_check
        $error("combo_lock_fsm: illegal parameter set");
    end

`ifdef COMBO_LOCK_LOCKOUT_EN
    localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned TMR_W  = $clog2(LOCKOUT_MS + 1);

    typedef enum logic [1:0] {LOCKED, UNLOCKED, LOCKOUT} state_t;

    logic [FAIL_W-1:0] fails_q, fails_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
`else
    typedef enum logic [1:0] {LOCKED, UNLOCKED} state_t;
`endif

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             err_q, err_d;
    logic             open_q, lock_q;
    logic             actuate_q, open_cls_q, count_en_q, clr_q, blank_q;
    logic             clr_d;

    logic             open_edge_c, lock_edge_c, match_c;
    logic [7:0]       code_entry_c;

    // Entry compare: BCD digits above 9 can never match a stored code digit.
    always_comb begin
        open_edge_c  = bus.open & ~open_q;
        lock_edge_c  = bus.lock & ~lock_q;
        code_entry_c = 8'(CODE >> {sel_q, 3'b000});
        match_c      = (bus.bcd0 <= 4'd9) && (bus.bcd1 <= 4'd9) &&
                       ({bus.bcd1, bus.bcd0} == code_entry_c);
    end

    // Next-state logic; open wins over a simultaneous dirch.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        err_d   = err_q;
        clr_d   = 1'b0;
`ifdef COMBO_LOCK_LOCKOUT_EN
        fails_d = fails_q;
        timer_d = timer_q;
`endif
        case (state_q)
            LOCKED: begin
                if (open_edge_c) begin
                    sel_d = '0;
                    err_d = 1'b0;
                    if (sel_q == LAST_SEL && !err_q && match_c) begin
                        state_d = UNLOCKED;
`ifdef COMBO_LOCK_LOCKOUT_EN
                        fails_d = '0;
`endif
                    end else begin
                        clr_d = 1'b1;
`ifdef COMBO_LOCK_LOCKOUT_EN
                        if (fails_q < FAIL_W'(MAX_TRIES)) fails_d = fails_q + 1'b1;
                        if (fails_d >= FAIL_W'(MAX_TRIES)) begin
                            state_d = LOCKOUT;
                            timer_d = TMR_W'(LOCKOUT_MS - 1);
                        end
`endif
                    end
                end else if (bus.dirch) begin
                    if (sel_q != LAST_SEL) begin
                        err_d = err_q | ~match_c;
                        sel_d = sel_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            UNLOCKED: begin
                sel_d = '0;
                if (lock_edge_c && bus.doorCls) begin
                    state_d = LOCKED;
                    clr_d   = 1'b1;
                    err_d   = 1'b0;
                end
            end
`ifdef COMBO_LOCK_LOCKOUT_EN
            LOCKOUT: begin
                sel_d = '0;
                err_d = 1'b0;
                if (timer_q == '0) begin
                    state_d = LOCKED;
                    fails_d = '0;
                    clr_d   = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`endif
            default: begin
                state_d = LOCKED;
                sel_d   = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    // State, edge-detect and registered outputs decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LOCKED;
            sel_q      <= '0;
            err_q      <= 1'b0;
            open_q     <= 1'b0;
            lock_q     <= 1'b0;
            actuate_q  <= 1'b1;
            open_cls_q <= 1'b0;
            count_en_q <= 1'b1;
            clr_q      <= 1'b0;
            blank_q    <= 1'b0;
`ifdef COMBO_LOCK_LOCKOUT_EN
            fails_q    <= '0;
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            err_q      <= err_d;
            open_q     <= bus.open;
            lock_q     <= bus.lock;
            actuate_q  <= (state_d != UNLOCKED);
            open_cls_q <= (state_d == UNLOCKED);
            count_en_q <= (state_d == LOCKED);
            clr_q      <= clr_d;
            blank_q    <= (state_d != LOCKED);
`ifdef COMBO_LOCK_LOCKOUT_EN
            fails_q    <= fails_d;
            timer_q    <= timer_d;
`endif
        end
    end

    assign bus.actuateLock = actuate_q;
    assign bus.openCls     = open_cls_q;
    assign bus.countEn     = count_en_q;
    assign bus.clrCount    = clr_q;
    assign bus.blank       = blank_q;
    assign bus.sel         = sel_q;

endmodule
